cpu_control: RTL
================

# cpu_control

Multi-cycle control unit for the 8-bit simple processor. Accepts one 32-bit instruction per handshake, decodes it, drives the ALU operation select and operand-steering controls, then sequences the data-cache access and register-file write-back. It is the issuing end of the ALU interface: it produces the SELECT code and operand controls that the ALU consumes, and it consumes the ALU's ZERO flag. It sits between instruction fetch/PC logic, the register file, the ALU and the data cache.

## Interface
- No parameters. Widths are fixed: 8-bit datapath, 8 registers, 3-bit ALU select.
- CLK  in  1  system clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- INSTRUCTION  in  32  [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/immediate
- INSTR_VALID  in  1  instruction present
- INSTR_READY  out  1  unit idle, accepts instruction
- ZERO  in  1  ALU zero flag
- BUSYWAIT  in  1  data cache stall
- SELECT  out  3  ALU op: 000 fwd, 001 add, 010 and, 011 or
- TWOSCOMP  out  1  negate second operand (sub, beq)
- IMMSEL  out  1  ALU second operand is IMMEDIATE
- IMMEDIATE  out  8  INSTRUCTION[7:0]
- READREG1 / READREG2  out  3 each  INSTRUCTION[10:8] / [2:0]
- WRITEREG  out  3  INSTRUCTION[18:16]
- WRITEENABLE  out  1  register-file write strobe
- WRITESRC  out  1  0 = ALU RESULT, 1 = cache read data
- MEMREAD / MEMWRITE  out  1 each  data cache request
- JUMP / BRANCH  out  1 each  PC redirect pulse
- OFFSET  out  8  INSTRUCTION[23:16], signed word offset
- ILLEGAL  out  1  undefined-opcode pulse

## Operation
- Opcodes: loadi 00, mov 01, add 02, sub 03, and 04, or 05, j 06, beq 07, lwd 08, lwi 09, swd 0A, swi 0B; anything else is illegal.
- FSM states: IDLE, EXEC, MEM, WB.
- IDLE: INSTR_READY=1. When INSTR_VALID=1, INSTRUCTION is latched into the instruction register and the FSM moves to EXEC. Without INSTR_VALID it stays in IDLE.
- EXEC (1 cycle): SELECT, TWOSCOMP and IMMSEL are driven per opcode.
  - loadi/lwi/swi: SELECT=000, IMMSEL=1.
  - mov/lwd/swd: SELECT=000.
  - add: 001. sub: 001 with TWOSCOMP=1. and: 010. or: 011.
  - beq: 001 with TWOSCOMP=1. j: no ALU use.
- EXEC exits:
  - ALU ops → WB.
  - lw*/sw* → MEM.
  - j: JUMP=1 for this cycle, then IDLE.
  - beq: BRANCH=ZERO for this cycle, then IDLE.
  - illegal: ILLEGAL=1 for this cycle, then IDLE. No write or memory access.
- MEM: MEMREAD (lw*) or MEMWRITE (sw*) is held, along with SELECT and IMMSEL. Minimum one cycle. The FSM leaves on the first edge in MEM where BUSYWAIT=0: lw* → WB with WRITESRC=1, sw* → IDLE.
- WB (1 cycle): WRITEENABLE=1. WRITESRC is 0 for ALU ops and 1 for loads. Then IDLE.
- READREG1, READREG2, WRITEREG, IMMEDIATE and OFFSET come from the latched instruction and hold steady from EXEC through the end of the instruction.
- All strobes (WRITEENABLE, MEMREAD, MEMWRITE, JUMP, BRANCH, ILLEGAL) are 0 outside the states listed above.

## Timing
- Reset: a clock edge with RESET=1 puts the FSM in IDLE and clears the instruction register. While RESET is high, INSTR_READY=0 and every other output is 0. INSTR_READY rises in the first cycle after RESET falls.
- Reset mid-operation: it aborts the instruction with no further strobes. No write-back occurs even if the FSM was in MEM or WB.
- Latency from accept edge to INSTR_READY high:
  - ALU op: 3 cycles (EXEC, WB, IDLE).
  - j, beq, illegal: 2 cycles.
  - lw*: 4 + N cycles.
  - sw*: 3 + N cycles.
  - N is the number of extra MEM cycles with BUSYWAIT=1.
- Throughput: at most one instruction per 2 cycles. An instruction is never accepted outside IDLE.
- ZERO is sampled combinationally during EXEC. The ALU settles within one cycle (worst case 2 time units), so BRANCH is valid before the closing edge.
- If BUSYWAIT=0 on the first MEM edge, MEM lasts exactly 1 cycle.
- OFFSET is passed raw. The PC logic does the sign extension and the shift.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants (OP_LOADI … OP_SWI);
  - ALU select constants (ALU_FWD=000, ALU_ADD=001, ALU_AND=010, ALU_OR=011);
  - FSM state encoding.
  The ALU and the PC logic import the same constants.
- One combinational sub-module, instr_decode: maps the opcode to SELECT, TWOSCOMP, IMMSEL, class (alu/mem-load/mem-store/jump/branch) and illegal. The FSM and registers stay in cpu_control.

## Test plan
- Reset, then `add`: RESET for 2 cycles, then INSTRUCTION=0x02_03_01_02 with VALID → EXEC shows SELECT=001, READREG1=1, READREG2=2; next cycle WRITEENABLE=1, WRITEREG=3, WRITESRC=0; INSTR_READY high 3 cycles after accept.
- `beq`: 0x07_FE_01_02 with ZERO=1 in EXEC → BRANCH=1, TWOSCOMP=1, OFFSET=0xFE; repeated with ZERO=0 → BRANCH=0, no write.
- `lwi` with stall: 0x09_04_00_10, BUSYWAIT=1 for 3 MEM cycles → MEMREAD held 4 cycles, IMMSEL=1, IMMEDIATE=0x10; then WB with WRITEREG=4, WRITESRC=1.
- Illegal opcode 0x0F → ILLEGAL=1 for one cycle; WRITEENABLE, MEMREAD and MEMWRITE all stay 0; back to IDLE.
- RESET asserted during MEM of `swd` → MEMWRITE=0 after that edge, no WB, INSTR_READY=0 during reset and 1 afterwards.
- VALID held high continuously over back-to-back `or`/`and` instructions → each accepted only in IDLE, with SELECT 011 then 010.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit simple processor: opcodes, ALU select
// codes, control-unit FSM encoding and instruction classes.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // How an instruction is sequenced after EXEC.
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_BRANCH = 3'd5
  } instr_cls_e;

endpackage

// File: rtl/cpu_control_instr_decode.sv
// Combinational opcode decoder: ALU controls, sequencing class and the
// illegal-opcode flag for one 8-bit opcode.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic [2:0] o_select,
  output logic       o_twoscomp,
  output logic       o_immsel,
  output instr_cls_e o_cls,
  output logic       o_illegal
);

  // Map opcode to ALU select, operand steering and class
  always_comb begin
    o_select   = ALU_FWD;
    o_twoscomp = 1'b0;
    o_immsel   = 1'b0;
    o_cls      = CLS_NONE;
    o_illegal  = 1'b0;
    case (i_opcode)
      OP_LOADI: begin
        o_immsel = 1'b1;
        o_cls    = CLS_ALU;
      end
      OP_MOV: begin
        o_cls = CLS_ALU;
      end
      OP_ADD: begin
        o_select = ALU_ADD;
        o_cls    = CLS_ALU;
      end
      OP_SUB: begin
        o_select   = ALU_ADD;
        o_twoscomp = 1'b1;
        o_cls      = CLS_ALU;
      end
      OP_AND: begin
        o_select = ALU_AND;
        o_cls    = CLS_ALU;
      end
      OP_OR: begin
        o_select = ALU_OR;
        o_cls    = CLS_ALU;
      end
      OP_J: begin
        o_cls = CLS_JUMP;
      end
      OP_BEQ: begin
        o_select   = ALU_ADD;
        o_twoscomp = 1'b1;
        o_cls      = CLS_BRANCH;
      end
      OP_LWD: begin
        o_cls = CLS_LOAD;
      end
      OP_LWI: begin
        o_immsel = 1'b1;
        o_cls    = CLS_LOAD;
      end
      OP_SWD: begin
        o_cls = CLS_STORE;
      end
      OP_SWI: begin
        o_immsel = 1'b1;
        o_cls    = CLS_STORE;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control unit: accepts one instruction per handshake, drives
// the ALU controls, sequences the data-cache access and register write-back.
module cpu_control
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic        ZERO,
  input  logic        BUSYWAIT,
  output logic [2:0]  SELECT,
  output logic        TWOSCOMP,
  output logic        IMMSEL,
  output logic [7:0]  IMMEDIATE,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [2:0]  WRITEREG,
  output logic        WRITEENABLE,
  output logic        WRITESRC,
  output logic        MEMREAD,
  output logic        MEMWRITE,
  output logic        JUMP,
  output logic        BRANCH,
  output logic [7:0]  OFFSET,
  output logic        ILLEGAL
);

  state_e     r_state;
  logic [31:0] r_ir;
  logic [2:0] r_select;
  logic       r_twoscomp;
  logic       r_immsel;
  instr_cls_e r_cls;
  logic       r_we;
  logic       r_wsrc;
  logic       r_memread;
  logic       r_memwrite;
  logic       r_jump;
  logic       r_branch_en;
  logic       r_illegal;

  logic [2:0] w_select;
  logic       w_twoscomp;
  logic       w_immsel;
  instr_cls_e w_cls;
  logic       w_illegal;
  logic       w_unused_bits;

  // Decode the incoming opcode so controls are registered on the accept edge
  instr_decode u_decode (
    .i_opcode   (INSTRUCTION[31:24]),
    .o_select   (w_select),
    .o_twoscomp (w_twoscomp),
    .o_immsel   (w_immsel),
    .o_cls      (w_cls),
    .o_illegal  (w_illegal)
  );

  // Instruction sequencing FSM with registered control outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_ir        <= 32'd0;
      r_select    <= ALU_FWD;
      r_twoscomp  <= 1'b0;
      r_immsel    <= 1'b0;
      r_cls       <= CLS_NONE;
      r_we        <= 1'b0;
      r_wsrc      <= 1'b0;
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
      r_jump      <= 1'b0;
      r_branch_en <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (INSTR_VALID) begin
            r_ir        <= INSTRUCTION;
            r_select    <= w_select;
            r_twoscomp  <= w_twoscomp;
            r_immsel    <= w_immsel;
            r_cls       <= w_cls;
            r_jump      <= (w_cls == CLS_JUMP);
            r_branch_en <= (w_cls == CLS_BRANCH);
            r_illegal   <= w_illegal;
            r_state     <= ST_EXEC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_jump      <= 1'b0;
          r_branch_en <= 1'b0;
          r_illegal   <= 1'b0;
          case (r_cls)
            CLS_ALU: begin
              r_we    <= 1'b1;
              r_wsrc  <= 1'b0;
              r_state <= ST_WB;
            end
            CLS_LOAD: begin
              r_memread <= 1'b1;
              r_state   <= ST_MEM;
            end
            CLS_STORE: begin
              r_memwrite <= 1'b1;
              r_state    <= ST_MEM;
            end
            default: begin
              // jump, branch and illegal finish in EXEC
              r_select   <= ALU_FWD;
              r_twoscomp <= 1'b0;
              r_immsel   <= 1'b0;
              r_state    <= ST_IDLE;
            end
          endcase
        end
        ST_MEM: begin
          if (!BUSYWAIT) begin
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            if (r_cls == CLS_LOAD) begin
              r_we    <= 1'b1;
              r_wsrc  <= 1'b1;
              r_state <= ST_WB;
            end else begin
              r_select   <= ALU_FWD;
              r_twoscomp <= 1'b0;
              r_immsel   <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end else begin
            r_state <= ST_MEM;
          end
        end
        ST_WB: begin
          r_we       <= 1'b0;
          r_wsrc     <= 1'b0;
          r_select   <= ALU_FWD;
          r_twoscomp <= 1'b0;
          r_immsel   <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Opcode and upper src1 bits are held in the register but drive no output
  assign w_unused_bits = ^{r_ir[31:24], r_ir[15:11]};

  assign INSTR_READY = (r_state == ST_IDLE) & ~RESET;
  assign SELECT      = r_select;
  assign TWOSCOMP    = r_twoscomp;
  assign IMMSEL      = r_immsel;
  assign IMMEDIATE   = r_ir[7:0];
  assign READREG1    = r_ir[10:8];
  assign READREG2    = r_ir[2:0];
  assign WRITEREG    = r_ir[18:16];
  assign OFFSET      = r_ir[23:16];
  assign WRITEENABLE = r_we;
  assign WRITESRC    = r_wsrc;
  assign MEMREAD     = r_memread;
  assign MEMWRITE    = r_memwrite;
  assign JUMP        = r_jump;
  // ZERO settles within the EXEC cycle, so the branch decision is taken live
  assign BRANCH      = r_branch_en & ZERO;
  assign ILLEGAL     = r_illegal;

endmodule
